// File: rtl/sym_if.sv
// Handshake/status bundle between the level controller, the symbol generator
// and the display/input-compare stage.
interface sym_if #(
  parameter int SYM_WIDTH = 4
);
  logic                 newLevel;
  logic                 victory;
  logic [3:0]           curLevel;
  logic [31:0]          symGenMax;
  logic                 symReady;
  logic                 symValid;
  logic [SYM_WIDTH-1:0] symOut;
  logic [7:0]           symCount;
  logic                 overflow;
  logic                 genActive;

  modport master (
    output newLevel, victory, curLevel, symGenMax, symReady,
    input  symValid, symOut, symCount, overflow, genActive
  );

  modport slave (
    input  newLevel, victory, curLevel, symGenMax, symReady,
    output symValid, symOut, symCount, overflow, genActive
  );
endinterface

// File: rtl/sym_generator.sv
// Periodic pseudo-random symbol generator feeding a small FWFT FIFO.
// Restarts on newLevel, freezes generation on victory until Reset.
module sym_generator #(
  parameter int          DEPTH     = 4,
  parameter int          SYM_WIDTH = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic   Clk100M,
  input logic   Reset,
  sym_if.slave  bus
);
  localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  function automatic logic [SYM_WIDTH-1:0] level_mask(input logic [3:0] lvl);
    logic [15:0] m;
    if (lvl <= 4'd1) begin
      m = 16'h0003;
    end else if (lvl == 4'd2) begin
      m = 16'h0007;
    end else begin
      m = 16'h000F;
    end
    return m[SYM_WIDTH-1:0];
  endfunction

  // Fibonacci form, taps 16,14,13,11, shifting toward bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  state_t                state_r, state_nxt_s;
  logic [31:0]           tick_cnt_r, tick_cnt_nxt_s, period_r;
  logic [SYM_WIDTH-1:0]  mask_r;
  logic [15:0]           lfsr_r;
  logic [SYM_WIDTH-1:0]  mem_r [DEPTH];
  logic [AW-1:0]         rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [AW:0]           count_r, count_nxt_s;
  logic [7:0]            sym_count_r, sym_count_nxt_s;
  logic                  overflow_r, overflow_nxt_s;
  logic                  valid_r, gen_active_r;
  logic [SYM_WIDTH-1:0]  sym_out_r, head_nxt_s, sym_s;
  logic                  accept_s, tick_s, full_s, pop_s, push_s, drop_s;

  // Next-state, tick, FIFO control and next output values.
  always_comb begin
    state_nxt_s     = state_r;
    accept_s        = 1'b0;
    tick_s          = 1'b0;
    full_s          = (count_r == FULL_CNT);
    pop_s           = valid_r && bus.symReady;
    push_s          = 1'b0;
    drop_s          = 1'b0;
    sym_s           = lfsr_r[SYM_WIDTH-1:0] & mask_r;
    tick_cnt_nxt_s  = 32'd0;
    rd_ptr_nxt_s    = rd_ptr_r;
    wr_ptr_nxt_s    = wr_ptr_r;
    count_nxt_s     = count_r;
    sym_count_nxt_s = sym_count_r;
    overflow_nxt_s  = overflow_r;
    head_nxt_s      = '0;

    case (state_r)
      ST_IDLE: begin
        if (bus.victory) begin
          state_nxt_s = ST_HALT;
        end else if (bus.newLevel) begin
          state_nxt_s = ST_RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        tick_s = (tick_cnt_r == (period_r - 32'd1));
        if (bus.victory) begin
          state_nxt_s = ST_HALT;
        end else if (bus.newLevel) begin
          state_nxt_s = ST_RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      rd_ptr_nxt_s    = '0;
      wr_ptr_nxt_s    = '0;
      count_nxt_s     = '0;
      sym_count_nxt_s = 8'd0;
      overflow_nxt_s  = 1'b0;
    end else begin
      tick_cnt_nxt_s = (state_r == ST_RUN) ? (tick_s ? 32'd0 : tick_cnt_r + 32'd1) : 32'd0;
      push_s         = tick_s && (!full_s || pop_s);
      drop_s         = tick_s && full_s && !pop_s;
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        if (sym_count_r != 8'd255) begin
          sym_count_nxt_s = sym_count_r + 8'd1;
        end else begin
          sym_count_nxt_s = sym_count_r;
        end
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_ONE;
        2'b01:   count_nxt_s = count_r - CNT_ONE;
        default: count_nxt_s = count_r;
      endcase
      if (drop_s) begin
        overflow_nxt_s = 1'b1;
      end else begin
        overflow_nxt_s = overflow_r;
      end
    end

    // A push into an otherwise-empty FIFO is the head before it reaches memory.
    if (count_nxt_s == '0) begin
      head_nxt_s = '0;
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = sym_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // State, counters, LFSR, FIFO storage and registered outputs.
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      tick_cnt_r   <= 32'd0;
      period_r     <= 32'd0;
      mask_r       <= '0;
      lfsr_r       <= LFSR_SEED;
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      count_r      <= '0;
      sym_count_r  <= 8'd0;
      overflow_r   <= 1'b0;
      valid_r      <= 1'b0;
      sym_out_r    <= '0;
      gen_active_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      state_r      <= state_nxt_s;
      tick_cnt_r   <= tick_cnt_nxt_s;
      lfsr_r       <= lfsr_step(lfsr_r);
      rd_ptr_r     <= rd_ptr_nxt_s;
      wr_ptr_r     <= wr_ptr_nxt_s;
      count_r      <= count_nxt_s;
      sym_count_r  <= sym_count_nxt_s;
      overflow_r   <= overflow_nxt_s;
      valid_r      <= (count_nxt_s != '0);
      sym_out_r    <= head_nxt_s;
      gen_active_r <= (state_nxt_s == ST_RUN);
      if (accept_s) begin
        period_r <= (bus.symGenMax < 32'd2) ? 32'd2 : bus.symGenMax;
        mask_r   <= level_mask(bus.curLevel);
      end else begin
        period_r <= period_r;
        mask_r   <= mask_r;
      end
      if (push_s) begin
        mem_r[wr_ptr_r] <= sym_s;
      end
    end
  end

  assign bus.symValid  = valid_r;
  assign bus.symOut    = sym_out_r;
  assign bus.symCount  = sym_count_r;
  assign bus.overflow  = overflow_r;
  assign bus.genActive = gen_active_r;
endmodule

// File: tb/tb_sym_generator.sv
// Directed self-checking bench for sym_generator: tick timing, alphabet masks,
// FIFO fill/overflow/push+pop, restart, victory halt and reset behaviour.
module tb_sym_generator;
  logic        Clk100M;
  logic        Reset;
  logic [15:0] lfsr_m;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_sym;
  logic [3:0]  first_sym;
  int          n_checks;
  int          n_pass;

  sym_if #(.SYM_WIDTH(4)) bus ();

  sym_generator #(.DEPTH(4), .SYM_WIDTH(4), .LFSR_SEED(16'hACE1)) dut (
    .Clk100M (Clk100M),
    .Reset   (Reset),
    .bus     (bus.slave)
  );

  initial Clk100M = 1'b0;
  always #5 Clk100M = ~Clk100M;

  // Reference LFSR: C-style right-shift form of x^16+x^14+x^13+x^11+1.
  always @(posedge Clk100M) begin
    logic [15:0] b;
    b = (lfsr_m ^ (lfsr_m >> 2) ^ (lfsr_m >> 3) ^ (lfsr_m >> 5)) & 16'h0001;
    lfsr_m <= Reset ? 16'hACE1 : ((lfsr_m >> 1) | (b << 15));
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk100M);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"},  32'(bus.symValid),  32'd0);
    check({tag, "_out"},    32'(bus.symOut),    32'd0);
    check({tag, "_count"},  32'(bus.symCount),  32'd0);
    check({tag, "_ovf"},    32'(bus.overflow),  32'd0);
    check({tag, "_active"}, 32'(bus.genActive), 32'd0);
  endtask

  task automatic new_level(input logic [31:0] per, input logic [3:0] lvl);
    bus.newLevel  = 1'b1;
    bus.symGenMax = per;
    bus.curLevel  = lvl;
    step(1);
    bus.newLevel  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    bus.newLevel  = 1'b0;
    bus.victory   = 1'b0;
    bus.curLevel  = 4'd0;
    bus.symGenMax = 32'd0;
    bus.symReady  = 1'b0;
    do_reset();
    check_reset_vals("rst");

    // Period 10, level 1, consumer always ready.
    bus.symReady = 1'b1;
    new_level(32'd10, 4'd1);
    check("l1_active", 32'(bus.genActive), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step((k == 1) ? 9 : 8);
      check("l1_pre_valid", 32'(bus.symValid), 32'd0);
      exp_sym = lfsr_m[3:0] & 4'h3;
      if (k == 1) first_sym = exp_sym;
      step(1);
      check("l1_valid", 32'(bus.symValid), 32'd1);
      check("l1_sym",   32'(bus.symOut),   32'(exp_sym));
      check("l1_count", 32'(bus.symCount), 32'(k));
      step(1);
      check("l1_popped", 32'(bus.symValid), 32'd0);
    end

    // Period 5, level 3, consumer stalled: fill then overflow.
    bus.symReady = 1'b0;
    new_level(32'd5, 4'd3);
    check("fill_flush", 32'(bus.symValid), 32'd0);
    check("fill_cnt0",  32'(bus.symCount), 32'd0);
    exp_q.delete();
    for (int k = 1; k <= 5; k++) begin
      step(4);
      exp_sym = lfsr_m[3:0];
      if (k <= 4) exp_q.push_back(exp_sym);
      step(1);
      check("fill_count", 32'(bus.symCount), 32'((k < 4) ? k : 4));
      check("fill_head",  32'(bus.symOut),   32'(exp_q[0]));
      check("fill_ovf",   32'(bus.overflow), 32'((k == 5) ? 1 : 0));
    end
    step(15);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    check("ovf_count",  32'(bus.symCount), 32'd4);
    check("ovf_head",   32'(bus.symOut),   32'(exp_q[0]));
    bus.symReady = 1'b1;
    step(1);
    bus.symReady = 1'b0;
    void'(exp_q.pop_front());
    check("pop1_head",  32'(bus.symOut),   32'(exp_q[0]));

    // Restart with 3 entries queued and overflow set; ready held through the restart.
    bus.symReady = 1'b1;
    new_level(32'd3, 4'd2);
    check("rs_valid", 32'(bus.symValid), 32'd0);
    check("rs_count", 32'(bus.symCount), 32'd0);
    check("rs_ovf",   32'(bus.overflow), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step(2);
      check("l2_pre_valid", 32'(bus.symValid), 32'd0);
      exp_sym = lfsr_m[3:0] & 4'h7;
      step(1);
      check("l2_valid", 32'(bus.symValid), 32'd1);
      check("l2_sym",   32'(bus.symOut),   32'(exp_sym));
      check("l2_count", 32'(bus.symCount), 32'(k));
    end

    // Full FIFO with ready only in tick cycles: push+pop keeps it full.
    bus.symReady = 1'b0;
    new_level(32'd5, 4'd3);
    exp_q.delete();
    for (int k = 1; k <= 4; k++) begin
      step(4);
      exp_q.push_back(lfsr_m[3:0]);
      step(1);
    end
    check("full_count", 32'(bus.symCount), 32'd4);
    for (int j = 1; j <= 2; j++) begin
      step(4);
      exp_sym = lfsr_m[3:0];
      bus.symReady = 1'b1;
      step(1);
      bus.symReady = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(exp_sym);
      check("pp_count", 32'(bus.symCount), 32'(4 + j));
      check("pp_ovf",   32'(bus.overflow), 32'd0);
      check("pp_head",  32'(bus.symOut),   32'(exp_q[0]));
    end
    bus.symReady = 1'b1;
    step(2);
    bus.symReady = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    check("pop2_head", 32'(bus.symOut), 32'(exp_q[0]));

    // victory together with newLevel: halt, drain remaining two, ignore restart.
    bus.victory = 1'b1;
    new_level(32'd7, 4'd1);
    check("halt_active", 32'(bus.genActive), 32'd0);
    check("halt_valid",  32'(bus.symValid),  32'd1);
    check("halt_count",  32'(bus.symCount),  32'd6);
    step(10);
    check("halt_noticks", 32'(bus.symCount), 32'd6);
    check("halt_head",    32'(bus.symOut),   32'(exp_q[0]));
    bus.symReady = 1'b1;
    step(1);
    void'(exp_q.pop_front());
    check("drain1_valid", 32'(bus.symValid), 32'd1);
    check("drain1_head",  32'(bus.symOut),   32'(exp_q[0]));
    step(1);
    check("drain2_valid", 32'(bus.symValid), 32'd0);
    check("drain2_out",   32'(bus.symOut),   32'd0);
    bus.symReady = 1'b0;
    new_level(32'd4, 4'd1);
    check("halt_ignore_nl", 32'(bus.genActive), 32'd0);
    step(6);
    check("halt_stay_empty", 32'(bus.symValid), 32'd0);
    check("halt_cnt_kept",   32'(bus.symCount), 32'd6);

    // symGenMax=0 clamps to period 2.
    bus.victory = 1'b0;
    do_reset();
    check_reset_vals("rst2");
    bus.symReady = 1'b1;
    new_level(32'd0, 4'd1);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check("p2_pre_valid", 32'(bus.symValid), 32'd0);
      exp_sym = lfsr_m[3:0] & 4'h3;
      step(1);
      check("p2_valid", 32'(bus.symValid), 32'd1);
      check("p2_sym",   32'(bus.symOut),   32'(exp_sym));
      check("p2_count", 32'(bus.symCount), 32'(k));
    end

    // Mid-run Reset, then replay the first level-1 run from the seed.
    Reset = 1'b1;
    step(1);
    check_reset_vals("midrst");
    step(1);
    Reset = 1'b0;
    new_level(32'd10, 4'd1);
    step(10);
    check("replay_valid", 32'(bus.symValid), 32'd1);
    check("replay_sym",   32'(bus.symOut),   32'(first_sym));
    check("replay_count", 32'(bus.symCount), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
